// File: rtl/pipe_addsub_vr_if.sv
// Stream bundle for pipe_addsub_vr: operand beat in, result beat out,
// plus the pipeline occupancy flag. The master is the side that produces
// operands and consumes results; the slave is the adder pipeline.
interface pipe_addsub_vr_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/pipe_addsub_vr.sv
// Parametrised pipelined add/subtract with carry/borrow-in.
// Stage 1 registers the operands, stage 2 computes the full-precision
// WIDTH+1 result, stages 3..STAGES are pure delay. The whole pipe moves on
// one global advance (no bubble squeezing), so a stalled output freezes
// every stage and in_ready simply mirrors advance.
module pipe_addsub_vr #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_addsub_vr_if.slave   bus
);

  localparam int RW = WIDTH + 1;

  logic                      advance_s;
  logic [STAGES:1]           v_q;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic                      cin_q;
  logic                      op_sub_q;
  logic [STAGES:2][RW-1:0]   r_q;
  logic [RW-1:0]             r_d;
  logic [RW-1:0]             cin_ext_s;

  // Widen an operand to the result width (sign- or zero-extension).
  function automatic logic [RW-1:0] ext(input logic [WIDTH-1:0] x);
    logic [RW-1:0] y;
    if (SIGNED != 0) begin
      y = {x[WIDTH-1], x};
    end else begin
      y = {1'b0, x};
    end
    return y;
  endfunction

  assign advance_s = ~v_q[STAGES] | bus.out_ready;
  assign cin_ext_s = {{WIDTH{1'b0}}, cin_q};

  // Stage-2 arithmetic; wraps modulo 2^(WIDTH+1) by construction.
  always_comb begin
    r_d = '0;
    if (op_sub_q) begin
      r_d = ext(a_q) - ext(b_q) - cin_ext_s;
    end else begin
      r_d = ext(a_q) + ext(b_q) + cin_ext_s;
    end
  end

  // Valid shift chain plus stage-1 operand capture, all gated by advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_sub_q <= 1'b0;
    end else if (advance_s) begin
      v_q <= {v_q[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        cin_q    <= bus.cin;
        op_sub_q <= bus.op_sub;
      end
    end
  end

  // Result and delay stages; a stage only loads when the stage feeding it
  // holds a valid beat, so bubbles leave the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (advance_s) begin
      if (v_q[1]) begin
        r_q[2] <= r_d;
      end
      for (int k = 3; k <= STAGES; k++) begin
        if (v_q[k-1]) begin
          r_q[k] <= r_q[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = v_q[STAGES];
  assign bus.sum       = r_q[STAGES];
  assign bus.busy      = |v_q;

endmodule

// File: tb/tb_pipe_addsub_vr.sv
// Self-checking bench for pipe_addsub_vr: directed latency, signed, borrow,
// backpressure and reset cases plus a long randomized stream scored against
// an arithmetic reference model.
module tb_pipe_addsub_vr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_addsub_vr_if #(.WIDTH(8))  if0 ();
  pipe_addsub_vr_if #(.WIDTH(8))  if1 ();
  pipe_addsub_vr_if #(.WIDTH(16)) if2 ();
  pipe_addsub_vr_if #(.WIDTH(16)) if3 ();

  pipe_addsub_vr #(.WIDTH(8),  .STAGES(3), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pipe_addsub_vr #(.WIDTH(8),  .STAGES(3), .SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipe_addsub_vr #(.WIDTH(16), .STAGES(2), .SIGNED(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  pipe_addsub_vr #(.WIDTH(16), .STAGES(5), .SIGNED(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on (optionally sign-interpreted) operands,
  // reduced modulo 2^(w+1).
  function automatic longint ref_op(input longint a, input longint b, input longint c,
                                    input longint s, input longint w, input longint sg);
    longint ae, be, r, m;
    ae = a;
    be = b;
    if (sg != 0) begin
      if (ae >= (longint'(1) << (w - 1))) ae = ae - (longint'(1) << w);
      if (be >= (longint'(1) << (w - 1))) be = be - (longint'(1) << w);
    end
    r = (s != 0) ? (ae - be - c) : (ae + be + c);
    m = (longint'(1) << (w + 1)) - 1;
    return r & m;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit v, input int a, input int b, input int c, input int s);
    if0.in_valid = v; if0.a = a[7:0]; if0.b = b[7:0]; if0.cin = c[0]; if0.op_sub = s[0];
  endtask

  task automatic drive1(input bit v, input int a, input int b, input int c, input int s);
    if1.in_valid = v; if1.a = a[7:0]; if1.b = b[7:0]; if1.cin = c[0]; if1.op_sub = s[0];
  endtask

  task automatic drive23(input bit v, input int a, input int b, input int c);
    if2.in_valid = v; if2.a = a[15:0]; if2.b = b[15:0]; if2.cin = c[0]; if2.op_sub = 1'b0;
    if3.in_valid = v; if3.a = a[15:0]; if3.b = b[15:0]; if3.cin = c[0]; if3.op_sub = 1'b0;
  endtask

  initial begin
    longint   exp_q[$];
    longint   e;
    logic [8:0] held;
    int       sent, got, stall, ra, rb, rc, rs;
    bit       stall_done, seen;

    drive0(1'b0, 0, 0, 0, 0); drive1(1'b0, 0, 0, 0, 0); drive23(1'b0, 0, 0, 0);
    if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1; if3.out_ready = 1'b1;

    // Reset state before any clock edge
    #1;
    check("rst_out_valid", if0.out_valid, 1'b0);
    check("rst_sum",       if0.sum,       9'd0);
    check("rst_busy",      if0.busy,      1'b0);
    check("rst_in_ready",  if0.in_ready,  1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Unsigned add: latency 3, one result per cycle
    drive0(1'b1, 255, 255, 1, 0);
    cyc(); drive0(1'b1, 10, 20, 0, 0);
    @(negedge clk); check("add_e1_ov", if0.out_valid, 1'b0); check("add_e1_rdy", if0.in_ready, 1'b1);
    cyc(); drive0(1'b1, 0, 0, 0, 0);
    @(negedge clk); check("add_e2_ov", if0.out_valid, 1'b0);
    cyc(); drive0(1'b0, 0, 0, 0, 0);
    @(negedge clk); check("add_r0_ov", if0.out_valid, 1'b1); check("add_r0_sum", if0.sum, 64'd511);
    cyc();
    @(negedge clk); check("add_r1_ov", if0.out_valid, 1'b1); check("add_r1_sum", if0.sum, 64'd30);
    cyc();
    @(negedge clk); check("add_r2_ov", if0.out_valid, 1'b1); check("add_r2_sum", if0.sum, 64'd0);
    cyc();
    @(negedge clk); check("add_drain_ov", if0.out_valid, 1'b0); check("add_drain_busy", if0.busy, 1'b0);

    // Unsigned subtract with borrow-in: 5-7-1 = -3
    cyc(); drive0(1'b1, 5, 7, 1, 1);
    cyc(); drive0(1'b0, 0, 0, 0, 0);
    cyc(); cyc();
    @(negedge clk); check("sub_ov", if0.out_valid, 1'b1); check("sub_sum", if0.sum, 64'h1FD);

    // Signed mode
    cyc(); drive1(1'b1, 8'h80, 8'h80, 0, 0);
    cyc(); drive1(1'b1, 8'h7F, 8'h80, 0, 1);
    cyc(); drive1(1'b0, 0, 0, 0, 0);
    cyc();
    @(negedge clk); check("sgn_add_ov", if1.out_valid, 1'b1); check("sgn_add_sum", if1.sum, 64'h100);
    cyc();
    @(negedge clk); check("sgn_sub_ov", if1.out_valid, 1'b1); check("sgn_sub_sum", if1.sum, 64'h0FF);

    // Depth sweep: STAGES=2 and 5 at WIDTH=16, max-value add
    cyc(); drive23(1'b1, 65535, 65535, 1);
    cyc(); drive23(1'b0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("depth2_ov", if2.out_valid, (c == 2));
      check("depth5_ov", if3.out_valid, (c == 5));
      if (c == 2) check("depth2_sum", if2.sum, 64'd131071);
      if (c == 5) check("depth5_sum", if3.sum, 64'd131071);
      cyc();
    end

    // Backpressure: 6 beats, 4-cycle output stall, then in-order drain
    sent = 0; got = 0; stall = 0; stall_done = 1'b0; held = '0;
    exp_q.delete();
    for (int cy = 0; cy < 80 && got < 6; cy++) begin
      ra = sent * 40 + 3; rb = sent * 7 + 1; rc = sent & 1; rs = (sent >= 3) ? 1 : 0;
      drive0(sent < 6, ra, rb, rc, rs);
      if0.out_ready = stall_done;
      @(negedge clk);
      if (if0.out_valid && !if0.out_ready) begin
        if (stall == 0) held = if0.sum;
        else check("bp_sum_stable", if0.sum, held);
        check("bp_in_ready", if0.in_ready, 1'b0);
        check("bp_busy", if0.busy, 1'b1);
        stall++;
        if (stall == 4) stall_done = 1'b1;
      end
      if (if0.out_valid && if0.out_ready) begin
        if (exp_q.size() == 0) check("bp_extra", 1'b1, 1'b0);
        else begin e = exp_q.pop_front(); check("bp_data", if0.sum, e); end
        got++;
      end
      if (if0.in_valid && if0.in_ready) begin
        exp_q.push_back(ref_op(ra, rb, rc, rs, 8, 0));
        sent++;
      end
      cyc();
    end
    drive0(1'b0, 0, 0, 0, 0); if0.out_ready = 1'b1;
    check("bp_got", got, 6);
    check("bp_left", exp_q.size(), 0);
    @(negedge clk); check("bp_no_dup", if0.out_valid, 1'b0);

    // Reset mid-stream with two beats in flight
    cyc(); drive0(1'b1, 1, 1, 0, 0);
    cyc(); drive0(1'b1, 2, 2, 0, 0);
    cyc(); drive0(1'b0, 0, 0, 0, 0);
    @(negedge clk); check("mid_busy_pre", if0.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ov",    if0.out_valid, 1'b0);
    check("mid_rst_sum",   if0.sum,       9'd0);
    check("mid_rst_busy",  if0.busy,      1'b0);
    check("mid_rst_ready", if0.in_ready,  1'b1);
    cyc(); cyc(); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if0.out_valid) seen = 1'b1;
      cyc();
    end
    check("mid_no_stale", seen, 1'b0);

    // Randomized handshake stream against the reference model
    sent = 0; got = 0;
    exp_q.delete();
    for (int cy = 0; cy < 60000 && got < 10000; cy++) begin
      ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
      rc = int'($urandom_range(1));   rs = int'($urandom_range(1));
      drive0((sent < 10000) && ($urandom_range(3) != 0), ra, rb, rc, rs);
      if0.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (if0.out_valid && if0.out_ready) begin
        if (exp_q.size() == 0) check("rnd_extra", 1'b1, 1'b0);
        else begin e = exp_q.pop_front(); check("rnd_data", if0.sum, e); end
        got++;
      end
      if (if0.in_valid && if0.in_ready) begin
        exp_q.push_back(ref_op(ra, rb, rc, rs, 8, 0));
        sent++;
      end
      cyc();
    end
    drive0(1'b0, 0, 0, 0, 0);
    check("rnd_got", got, 10000);
    check("rnd_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_addsub_vr.md
Name: pipe_addsub_vr

Overview:
- Parametrised successor to the team's fixed 8-bit, 3-stage pipelined adder.
- Adds or subtracts two WIDTH-bit operands with carry/borrow-in, in unsigned or signed mode.
- Result is full-precision WIDTH+1 bits. Latency is STAGES cycles.
- Valid/ready handshake on both sides with global stall, so it can sit in any streaming datapath with backpressure.

Parameters:
- WIDTH, 8: operand width in bits; must be >= 1.
- STAGES, 3: pipeline depth = latency in cycles from accepted input to out_valid; must be >= 2.
- SIGNED, 0: 0 = operands zero-extended, 1 = operands sign-extended to WIDTH+1 before the operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (subtract)
- op_sub  input  1  0 = a+b+cin, 1 = a-b-cin
- out_valid  output  1  sum holds a valid result
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH+1  result, two's complement when SIGNED=1 or op_sub=1
- busy  output  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state, while rst_n=0:
  - all stage valid bits = 0 and all data registers = 0
  - out_valid = 0, sum = 0, busy = 0
  - in_ready = 1, since it is derived from out_valid.
- Reset deassertion is synchronous to clk by the integrator. Reset mid-operation drops all in-flight beats; no partial output.
- Advance signal: advance = ~out_valid | out_ready. This is a global stall: every stage moves together.
- Input handshake:
  - in_ready = advance, combinational.
  - A beat is accepted when in_valid & in_ready.
  - in_ready must not depend on in_valid.
- Stage 1 (on advance): v1 <= in_valid. If in_valid, it also captures a, b, cin, op_sub.
- Stage 2 (on advance): v2 <= v1. If v1, it computes the result:
  - ext(x) = SIGNED ? {x[WIDTH-1], x} : {1'b0, x}
  - r = ext(a) + ext(b) + cin when op_sub=0
  - r = ext(a) - ext(b) - cin when op_sub=1
  - All arithmetic is modulo 2^(WIDTH+1).
- Stages 3..STAGES: pure delay. On advance, vk <= v(k-1), and data loads only when v(k-1)=1.
- Output:
  - out_valid = v(STAGES); sum = data register of stage STAGES.
  - With no stall, a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles of latency counting the accept cycle.
- Stall (out_valid=1, out_ready=0):
  - no register changes
  - sum and out_valid stay stable until the handshake completes
  - in_ready = 0
- Bubbles: data registers hold their last valid contents when the upstream valid is 0, so sum keeps the last delivered value when out_valid=0. The bench must check sum only when out_valid=1.
- Bubbles are not squeezed out. A pipeline with holes still drains at 1 stage per advance, and throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous events: the output handshake and an input accept in the same cycle is legal, and both take effect on that edge.
- Ordering: strictly in order, no drops, no duplicates.
- Range: the result always fits in WIDTH+1 bits for unsigned add and for signed add/sub, so there is no overflow flag.
  - Unsigned subtract yields the two's-complement difference.
  - sum[WIDTH] = 1 indicates a borrow.
- busy = |{v1..vSTAGES}.

Test Plan:
- Reset values: WIDTH=8, STAGES=3, SIGNED=0. Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0, sum=0, busy=0 and in_ready=1 immediately, without waiting for clk. No stale beat emerges after release.
- Unsigned add, latency and throughput: out_ready=1. Beats (255,255,cin=1), (10,20,0), (0,0,0) on consecutive cycles -> sum 511, 30, 0 on 3 consecutive cycles, first one 3 cycles after accept.
- Signed mode, SIGNED=1:
  - a=8'h80 (-128), b=8'h80, add -> sum=9'h100 (-256)
  - a=8'h7F, b=8'h80, op_sub=1 -> sum=9'h0FF (255)
- Unsigned subtract with borrow: a=5, b=7, op_sub=1, cin=1 -> sum=9'h1FD (-3, borrow bit 1).
- Backpressure:
  - Stream 6 beats. Hold out_ready=0 for 4 cycles once out_valid=1 -> sum stable, in_ready=0, busy=1.
  - Release -> all 6 results in order, none lost or duplicated.
  - Random in_valid/out_ready for 10k beats against a reference model -> zero mismatches.
- Depth sweep: STAGES=2 and STAGES=5, WIDTH=16 -> latency equals STAGES. Max-value add 65535+65535+1 = 131071.
